// File: rtl/milestone_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// milestone_pkg: shared owner/state encodings and mask helpers for the scheduler
// Rev 1.0
// -----------------------------------------------------------------------------
package milestone_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M1   = 2'd1,
    OWN_M2   = 2'd2,
    OWN_M3   = 2'd3
  } owner_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } sched_state_t;

  // Stages run in ascending order, so the lowest set bit is always next.
  function automatic owner_t lowest_stage(input logic [2:0] mask);
    owner_t own;
    if (mask[0]) begin
      own = OWN_M1;
    end else if (mask[1]) begin
      own = OWN_M2;
    end else if (mask[2]) begin
      own = OWN_M3;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

  function automatic logic [2:0] owner_onehot(input owner_t own);
    logic [2:0] oh;
    case (own)
      OWN_M1:  oh = 3'b001;
      OWN_M2:  oh = 3'b010;
      OWN_M3:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_watchdog.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stage_watchdog: saturating per-stage cycle counter with timeout flag
// Rev 1.0
// -----------------------------------------------------------------------------
module stage_watchdog #(
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  // The count is zero on the first run cycle, so LAST_CNT marks the final allowed cycle.
  assign timeout_o = (count_q >= LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/milestone_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// milestone_scheduler: sequences M1/M2/M3 with start/done handshake, watchdog, abort
// Rev 1.0
// -----------------------------------------------------------------------------
module milestone_scheduler
  import milestone_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             CLOCK_50_I,
  input  logic             reset,
  input  logic             go,
  input  logic [2:0]       stage_en,
  input  logic             abort,
  output logic             M1_start,
  output logic             M2_start,
  output logic             M3_start,
  input  logic             M1_done,
  input  logic             M2_done,
  input  logic             M3_done,
  output logic [1:0]       owner,
  output logic             mult_grant,
  output logic             busy,
  output logic             seq_done,
  output logic             error,
  output logic [1:0]       error_stage,
  output logic [CNT_W-1:0] last_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t     state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           error_stage_q, error_stage_d;
  logic [2:0]       mask_q, mask_d;
  logic [2:0]       start_q, start_d;
  logic             seq_done_q, seq_done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] last_cycles_q, last_cycles_d;

  logic [CNT_W-1:0] wd_count;
  logic             wd_timeout;
  logic             owner_done;
  logic [2:0]       owner_oh;
  logic [CNT_W-1:0] run_cycles;

  stage_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (CLOCK_50_I),
    .rst_i     (reset),
    .clear_i   (state_q == S_ARM),
    .en_i      (state_q == S_RUN),
    .count_o   (wd_count),
    .timeout_o (wd_timeout)
  );

  assign owner_oh   = owner_onehot(owner_q);
  // Only the owning stage's done is visible; stale or stray dones are masked out.
  assign owner_done = |({M3_done, M2_done, M1_done} & owner_oh);
  assign run_cycles = (wd_count == CNT_MAX) ? wd_count : (wd_count + CNT_W'(1));

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    error_stage_d = error_stage_q;
    mask_d        = mask_q;
    start_d       = start_q;
    seq_done_d    = 1'b0;
    error_d       = error_q;
    last_cycles_d = last_cycles_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          mask_d        = stage_en;
          error_d       = 1'b0;
          error_stage_d = OWN_NONE;
          if (stage_en != 3'b000) begin
            owner_d = lowest_stage(stage_en);
            state_d = S_ARM;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_ARM: begin
        start_d = owner_oh;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (owner_done) begin
          start_d       = 3'b000;
          last_cycles_d = run_cycles;
          mask_d        = mask_q & ~owner_oh;
          state_d       = S_GAP;
        end else if (wd_timeout) begin
          start_d       = 3'b000;
          error_d       = 1'b1;
          error_stage_d = owner_q;
          owner_d       = OWN_NONE;
          state_d       = S_IDLE;
        end
      end

      S_GAP: begin
        // Owner is held through this cycle so the stage's last SRAM write lands.
        if (mask_q != 3'b000) begin
          owner_d = lowest_stage(mask_q);
          state_d = S_ARM;
        end else begin
          owner_d = OWN_NONE;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        seq_done_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        start_d = 3'b000;
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any done/timeout outcome decided above.
    if (abort && (state_q != S_IDLE)) begin
      start_d       = 3'b000;
      owner_d       = OWN_NONE;
      state_d       = S_IDLE;
      seq_done_d    = 1'b0;
      error_d       = error_q;
      error_stage_d = error_stage_q;
      last_cycles_d = last_cycles_q;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_NONE;
      error_stage_q <= OWN_NONE;
      mask_q        <= 3'b000;
      start_q       <= 3'b000;
      seq_done_q    <= 1'b0;
      error_q       <= 1'b0;
      last_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      error_stage_q <= error_stage_d;
      mask_q        <= mask_d;
      start_q       <= start_d;
      seq_done_q    <= seq_done_d;
      error_q       <= error_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  assign M1_start    = start_q[0];
  assign M2_start    = start_q[1];
  assign M3_start    = start_q[2];
  assign owner       = owner_q;
  assign mult_grant  = (owner_q == OWN_M1) || (owner_q == OWN_M2);
  assign busy        = (state_q != S_IDLE);
  assign seq_done    = seq_done_q;
  assign error       = error_q;
  assign error_stage = error_stage_q;
  assign last_cycles = last_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_milestone_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_milestone_scheduler: directed scoreboard bench for milestone_scheduler
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_milestone_scheduler;

  localparam int unsigned CNT_W = 32;
  localparam logic [31:0] TO    = 32'd16;

  localparam int SIG_OWNER = 0;
  localparam int SIG_S1    = 1;
  localparam int SIG_GRANT = 4;
  localparam int SIG_BUSY  = 5;
  localparam int SIG_SDONE = 6;
  localparam int SIG_ERR   = 7;
  localparam int SIG_ESTG  = 8;
  localparam int SIG_LC    = 9;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic [2:0]       stage_en;
  logic             abort;
  logic             M1_start, M2_start, M3_start;
  logic             M1_done, M2_done, M3_done;
  logic [1:0]       owner;
  logic             mult_grant;
  logic             busy;
  logic             seq_done;
  logic             error;
  logic [1:0]       error_stage;
  logic [CNT_W-1:0] last_cycles;

  exp_t       sb[$];
  int         passed = 0;
  int         total  = 0;
  logic [2:0] seen_start;
  int         sdone_cnt;

  always #10 clk = ~clk;

  milestone_scheduler #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNT_W)
  ) dut (
    .CLOCK_50_I  (clk),
    .reset       (reset),
    .go          (go),
    .stage_en    (stage_en),
    .abort       (abort),
    .M1_start    (M1_start),
    .M2_start    (M2_start),
    .M3_start    (M3_start),
    .M1_done     (M1_done),
    .M2_done     (M2_done),
    .M3_done     (M3_done),
    .owner       (owner),
    .mult_grant  (mult_grant),
    .busy        (busy),
    .seq_done    (seq_done),
    .error       (error),
    .error_stage (error_stage),
    .last_cycles (last_cycles)
  );

  function automatic logic [31:0] observe(input int sig);
    logic [31:0] v;
    case (sig)
      SIG_OWNER: v = {30'd0, owner};
      1:         v = {31'd0, M1_start};
      2:         v = {31'd0, M2_start};
      3:         v = {31'd0, M3_start};
      SIG_GRANT: v = {31'd0, mult_grant};
      SIG_BUSY:  v = {31'd0, busy};
      SIG_SDONE: v = {31'd0, seq_done};
      SIG_ERR:   v = {31'd0, error};
      SIG_ESTG:  v = {30'd0, error_stage};
      SIG_LC:    v = last_cycles;
      default:   v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total = total + 1;
    assert (obs === exp_v) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, end input pulses, score.
  task automatic step();
    @(posedge clk);
    #1;
    go    = 1'b0;
    abort = 1'b0;
    seen_start = seen_start | {M3_start, M2_start, M1_start};
    if (seq_done) sdone_cnt = sdone_cnt + 1;
    drain();
  endtask

  task automatic clear_seen();
    seen_start = 3'b000;
    sdone_cnt  = 0;
  endtask

  task automatic set_done(input int stage, input logic v);
    case (stage)
      1:       M1_done = v;
      2:       M2_done = v;
      default: M3_done = v;
    endcase
  endtask

  // Called in the cycle before ARM; returns in the GAP cycle.
  task automatic run_stage(input int stage, input int n, input bit hold);
    push("arm_owner", SIG_OWNER, stage);
    push("arm_start", SIG_S1 + stage - 1, 0);
    push("arm_grant", SIG_GRANT, (stage <= 2) ? 1 : 0);
    step();
    for (int i = 0; i < n; i++) begin
      push("run_start", SIG_S1 + stage - 1, 1);
      push("run_owner", SIG_OWNER, stage);
      step();
      if ((i == n - 1) && !hold) set_done(stage, 1'b1);
    end
    push("gap_start", SIG_S1 + stage - 1, 0);
    push("gap_owner", SIG_OWNER, stage);
    push("gap_lc", SIG_LC, n);
    step();
    if (!hold) set_done(stage, 1'b0);
  endtask

  task automatic finish_seq();
    push("fin_owner", SIG_OWNER, 0);
    push("fin_busy", SIG_BUSY, 1);
    push("fin_nodone", SIG_SDONE, 0);
    step();
    push("seq_done", SIG_SDONE, 1);
    push("idle_busy", SIG_BUSY, 0);
    step();
    push("seq_done_pulse", SIG_SDONE, 0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; go = 1'b0; abort = 1'b0; stage_en = 3'b000;
    M1_done = 1'b0; M2_done = 1'b0; M3_done = 1'b0;
    clear_seen();
    step();
    push("rst_owner", SIG_OWNER, 0);
    push("rst_s1", 1, 0);
    push("rst_s2", 2, 0);
    push("rst_s3", 3, 0);
    push("rst_grant", SIG_GRANT, 0);
    push("rst_busy", SIG_BUSY, 0);
    push("rst_sdone", SIG_SDONE, 0);
    push("rst_err", SIG_ERR, 0);
    push("rst_estg", SIG_ESTG, 0);
    push("rst_lc", SIG_LC, 0);
    step();
    reset = 1'b0;
    step();

    // Single M1 stage, done on its 10th start-high cycle.
    clear_seen();
    stage_en = 3'b001; go = 1'b1;
    run_stage(1, 10, 1'b0);
    finish_seq();
    check("t1_seq_done_count", sdone_cnt, 1);

    // M2 then M3, M1 skipped.
    clear_seen();
    stage_en = 3'b110; go = 1'b1;
    run_stage(2, 5, 1'b0);
    run_stage(3, 5, 1'b0);
    finish_seq();
    check("t2_m1_never", {31'd0, seen_start[0]}, 0);
    check("t2_seq_done_count", sdone_cnt, 1);

    // M1 never completes: watchdog fires after TO run cycles.
    clear_seen();
    stage_en = 3'b011; go = 1'b1;
    push("t3_arm_owner", SIG_OWNER, 1);
    step();
    for (int i = 0; i < int'(TO); i++) begin
      push("t3_run_start", 1, 1);
      step();
    end
    push("t3_start_drop", 1, 0);
    push("t3_err", SIG_ERR, 1);
    push("t3_estg", SIG_ESTG, 1);
    push("t3_owner", SIG_OWNER, 0);
    push("t3_busy", SIG_BUSY, 0);
    step();
    step();
    step();
    check("t3_m2_never", {31'd0, seen_start[1]}, 0);
    check("t3_no_seq_done", sdone_cnt, 0);

    // Empty mask: clears error, seq_done two cycles after go.
    clear_seen();
    stage_en = 3'b000; go = 1'b1;
    push("t3b_err_clr", SIG_ERR, 0);
    push("t3b_estg_clr", SIG_ESTG, 0);
    push("t3b_busy", SIG_BUSY, 1);
    push("t3b_owner", SIG_OWNER, 0);
    push("t3b_sdone_early", SIG_SDONE, 0);
    step();
    push("t3b_seq_done", SIG_SDONE, 1);
    step();
    check("t3b_no_start", {29'd0, seen_start}, 0);

    // Abort during M2 run.
    clear_seen();
    stage_en = 3'b111; go = 1'b1;
    run_stage(1, 3, 1'b0);
    push("t4_arm_owner", SIG_OWNER, 2);
    step();
    for (int i = 0; i < 4; i++) begin
      push("t4_run_start", 2, 1);
      step();
    end
    abort = 1'b1;
    push("t4_start_drop", 2, 0);
    push("t4_owner", SIG_OWNER, 0);
    push("t4_busy", SIG_BUSY, 0);
    push("t4_grant", SIG_GRANT, 0);
    push("t4_err", SIG_ERR, 0);
    push("t4_lc", SIG_LC, 3);
    step();
    for (int i = 0; i < 4; i++) step();
    check("t4_m3_never", {31'd0, seen_start[2]}, 0);
    check("t4_no_seq_done", sdone_cnt, 0);

    // go while busy and stage_en changes mid-run are ignored.
    clear_seen();
    stage_en = 3'b010; go = 1'b1;
    push("t5_arm_owner", SIG_OWNER, 2);
    step();
    stage_en = 3'b101; go = 1'b1;
    push("t5_run_start", 2, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      push("t5_run_start", 2, 1);
      push("t5_owner", SIG_OWNER, 2);
      step();
      if (i == 2) M2_done = 1'b1;
    end
    push("t5_gap_start", 2, 0);
    push("t5_lc", SIG_LC, 4);
    step();
    M2_done = 1'b0;
    finish_seq();
    check("t5_m1_never", {31'd0, seen_start[0]}, 0);
    check("t5_m3_never", {31'd0, seen_start[2]}, 0);
    check("t5_seq_done_count", sdone_cnt, 1);

    // M1_done held high; stray M3_done ignored.
    clear_seen();
    M1_done = 1'b1; M3_done = 1'b1;
    stage_en = 3'b011; go = 1'b1;
    run_stage(1, 1, 1'b1);
    run_stage(2, 3, 1'b0);
    finish_seq();
    check("t6_m3_never", {31'd0, seen_start[2]}, 0);
    check("t6_seq_done_count", sdone_cnt, 1);
    M1_done = 1'b0; M3_done = 1'b0;

    // Reset in the middle of a run.
    stage_en = 3'b001; go = 1'b1;
    step();
    push("t7_running", 1, 1);
    step();
    reset = 1'b1;
    push("t7_s1", 1, 0);
    push("t7_owner", SIG_OWNER, 0);
    push("t7_busy", SIG_BUSY, 0);
    push("t7_grant", SIG_GRANT, 0);
    push("t7_lc", SIG_LC, 0);
    step();
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/milestone_scheduler.md
Name: milestone_scheduler

Overview:
Sequences the decoder milestones M1 (colourspace/upsample), M2 (IDCT) and M3 (lossless decode) after a UART image load completes. Owns the start/done handshake with each milestone and drives the owner select that the top level uses to steer the shared SRAM port and the three shared multipliers. Adds a per-stage watchdog, per-stage cycle count, and abort support.

Parameters:
TIMEOUT_CYCLES, 32'd100_000_000, RUN cycles allowed per stage before timeout error
CNT_W, 32, width of the stage cycle counter

Ports:
CLOCK_50_I  in  1  50 MHz clock
reset  in  1  synchronous, active-high reset
go  in  1  one-cycle pulse: image load finished, run enabled stages
stage_en  in  3  bit0=M1, bit1=M2, bit2=M3; sampled on accepted go
abort  in  1  one-cycle pulse: stop current sequence
M1_start / M2_start / M3_start  out  1 each  level start to milestone
M1_done / M2_done / M3_done  in  1 each  milestone done (level or pulse)
owner  out  2  owner_t: OWN_NONE=0 (VGA/UART path), OWN_M1, OWN_M2, OWN_M3
mult_grant  out  1  high when owner is OWN_M1 or OWN_M2
busy  out  1  high in any state except S_IDLE
seq_done  out  1  one-cycle pulse at end of successful sequence
error  out  1  sticky: timeout occurred
error_stage  out  2  owner_t of the stage that timed out
last_cycles  out  CNT_W  RUN cycle count of the most recently completed stage

Behaviour:
- Reset: state S_IDLE; all *_start=0; owner=OWN_NONE; mult_grant=0; busy=0; seq_done=0; error=0; error_stage=OWN_NONE; last_cycles=0; latched enable mask=0.
- States: S_IDLE, S_ARM, S_RUN, S_GAP, S_FINISH.
- S_IDLE: go=1 -> latch stage_en into mask, clear error/error_stage. If mask!=0: owner=lowest enabled stage, go to S_ARM. If mask==0: go to S_FINISH.
- S_ARM (1 cycle): owner valid, start still 0, cycle counter cleared. Go to S_RUN. Grant always precedes start by one cycle.
- S_RUN: start of the owning stage=1, others 0; counter increments each cycle. The owner's done sampled high -> start=0 on the next edge, last_cycles=counter+1, clear that mask bit, go to S_GAP. Done inputs of non-owning stages are ignored.
- S_GAP (1 cycle): owner held so the final SRAM write completes. Next cycle: if remaining mask!=0, owner=lowest remaining bit, go to S_ARM; else owner=OWN_NONE, go to S_FINISH.
- S_FINISH: seq_done=1 for exactly one cycle; go to S_IDLE.
- Timing: go at cycle 0 -> owner at cycle 1 -> start at cycle 2. Done at cycle n -> start low at n+1 -> next owner at n+2 -> next start at n+3.
- Timeout: in S_RUN, when counter reaches TIMEOUT_CYCLES-1 without done: start=0, error=1, error_stage=owner, owner=OWN_NONE, go to S_IDLE. No seq_done; the remaining stages are skipped.
- Done and timeout in the same cycle: done wins.
- abort in any non-idle state: next edge start=0, owner=OWN_NONE, go to S_IDLE; no seq_done; error unchanged. abort has priority over done and timeout. abort in S_IDLE is ignored.
- go while busy=1 is ignored. Changes to stage_en after go have no effect.
- Milestone done held high across stages: only the current owner's done is observed, and only in S_RUN.
- The counter saturates at the all-ones value.
- reset asserted mid-operation: all outputs return to reset values on the next edge.
- mult_grant is decoded combinationally from registered owner.

Decomposition:
- milestone_pkg: owner_t enum (OWN_NONE, OWN_M1, OWN_M2, OWN_M3), sched_state_t enum, and a function returning the lowest set bit of a 3-bit mask as owner_t.
- Sub-module stage_watchdog: clear/enable inputs, counter output, timeout flag output, saturating at all-ones, CNT_W and TIMEOUT_CYCLES parameters.
- The top-level SRAM and multiplier mux stays in the top level and keys on owner.

Test Plan:
- reset, then go with stage_en=3'b001; M1_done pulsed at the 10th start-high cycle -> owner=OWN_M1 at cycle 1; M1_start high cycles 2-11, low at 12; last_cycles=10; seq_done pulse at cycle 14; owner=OWN_NONE.
- stage_en=3'b110 with M2 and M3 done after 5 cycles each -> M1_start never asserted; owner sequence NONE,M2,M2(gap),M3,M3(gap),NONE; M3_start rises exactly 3 cycles after M2_done; single seq_done.
- TIMEOUT_CYCLES=16, stage_en=3'b011, M1 never done -> M1_start drops after 16 RUN cycles; error=1; error_stage=OWN_M1; M2_start never asserted; no seq_done; next go clears error.
- abort during M2 RUN with stage_en=3'b111 -> next cycle M2_start=0, owner=OWN_NONE, busy=0; M3 not run; no seq_done.
- go while busy and stage_en changed mid-run -> ignored; original mask completes; go with stage_en=0 -> seq_done exactly 2 cycles later; no start asserted.
- M1_done held high permanently, stage_en=3'b011 -> M1 finishes after 1 RUN cycle; M2 runs and waits for its own M2_done; stray M3_done ignored throughout.
